ysyx_22051086_icache: RTL and testbench
=======================================

# ysyx_22051086_icache

Direct-mapped, blocking instruction cache that sits directly upstream of the instruction-fetch stage. It accepts one fetch request at a time from the IFU (`if_arvalid` plus `nextpc`), returns one 32-bit instruction with a single-cycle valid pulse, and refills 16-byte lines from a burst read port toward memory. It also provides whole-cache invalidation for `fence.i`.

## Interface
- `SETS`, default 64: number of lines; a power of two.
- `LINE_BYTES`, fixed at 16: 4 instructions per line, refilled as 2 beats of 64 bits.
- `clk` input 1: the only clock.
- `rst` input 1: synchronous, active-high reset.
- `if_arvalid` input 1: one-cycle fetch request pulse from the IFU.
- `nextpc` input 64: fetch address, sampled when `if_arvalid` is high in IDLE.
- `cache_rdata` output 32: instruction word; holds its last value between responses.
- `cache_rdata_valid` output 1: one-cycle pulse that marks `cache_rdata` as valid.
- `fence_i` input 1: invalidate every line.
- `mem_arvalid` output 1: refill request valid.
- `mem_arready` input 1: refill request accepted.
- `mem_araddr` output 32: line-aligned refill address, `{addr[31:4], 4'b0}`.
- `mem_rvalid` input 1: refill beat valid. This port has no ready; the cache always accepts beats in REFILL.
- `mem_rdata` input 64: refill beat data. Beat 0 carries bytes 0–7 of the line; beat 1 carries bytes 8–15.
- `mem_rlast` input 1: marks the final refill beat.

## Operation
- Address split:
  - Offset is `addr[3:0]`.
  - Word select is `addr[3:2]`, with `addr[1:0]` ignored.
  - Index is `addr[4+log2(SETS)-1:4]`.
  - Tag is `addr[31:4+log2(SETS)]`.
  - `nextpc[63:32]` is ignored; the physical space is 32 bits.
- Storage:
  - Per set: a valid flop, a tag register, and a 128-bit data line.
  - Word `w` of a line occupies bits `[32w+31:32w]`.
- FSM states are IDLE, LOOKUP, MISS_AR, REFILL, RESP.
  - **IDLE:** if `if_arvalid`, latch `nextpc` into `req_addr` and go to LOOKUP.
  - **LOOKUP:** a hit is `valid[idx] && tag[idx] == req_tag`.
    - On a hit, register the selected word into `cache_rdata` and go to RESP.
    - On a miss, go to MISS_AR.
  - **MISS_AR:** drive `mem_arvalid=1` and hold `mem_araddr` stable until `mem_arready`, then go to REFILL with the beat counter at 0.
  - **REFILL:**
    - Each `mem_rvalid` beat writes into a 128-bit line buffer at the half selected by the beat counter, then the counter increments.
    - On a beat with `mem_rlast`, write the buffer (including the last beat) into `data[idx]`, set `tag[idx]`, and set `valid[idx]=1`.
    - In the same step, load `cache_rdata` with the requested word from the assembled line and go to RESP.
  - **RESP:** drive `cache_rdata_valid=1` for exactly this cycle, then go to IDLE.
- `if_arvalid` outside IDLE is ignored; the IFU guarantees at most one outstanding fetch.
- `fence_i`:
  - In IDLE it clears all valid bits that cycle.
  - In any other state it sets `fence_pend`. The clear happens on the first cycle back in IDLE, and `fence_pend` is then cleared.
  - If `fence_i` (or `fence_pend`) and `if_arvalid` coincide in IDLE, both take effect. The lookup for that request then sees the invalidated array and misses.
- A refill always overwrites the indexed line; no victim write-back is needed (read-only cache).

## Timing
- Reset values:
  - State is IDLE.
  - All valid bits are 0, and `fence_pend` is 0.
  - Outputs: `cache_rdata_valid=0`, `cache_rdata=0`, `mem_arvalid=0`, `mem_araddr=0`.
- Hit latency: with `if_arvalid` in cycle T, LOOKUP occurs at T+1 and `cache_rdata_valid` at T+2.
- Miss latency:
  - `mem_arvalid` first goes high at T+2.
  - With `mem_arready` at A and the `mem_rlast` beat at L, `cache_rdata_valid` rises at L+1.
  - The minimum is T+5 (arready at T+2, beats at T+3 and T+4).
- `mem_arvalid` must not drop before `mem_arready`, and `mem_araddr` must not change while it is high.
- `mem_rvalid` is ignored outside REFILL.
- Reset mid-refill:
  - Return to IDLE and drop `mem_arvalid`.
  - The partial line is discarded and no valid bit is set.
  - The memory side is reset by the same `rst`.
- Back-to-back operation: a new `if_arvalid` can be accepted in the cycle after RESP, so there is a minimum of 3 cycles between responses on hits.

## Structure
- A shared package holds:
  - the FSM state enum;
  - constants `LINE_BYTES=16`, `BEATS=2`, and `PADDR_W=32`;
  - tag/index/offset width functions of `SETS`.
- Sub-module `ysyx_22051086_icache_data`: a `SETS`×128-bit data array with one write port (full line) and one read port (word-selected). It can be swapped later for an SRAM macro.
- Tags, valid bits, the FSM, the line buffer, and `fence_pend` stay in the top module.

## Test plan
- **Cold miss:**
  - Stimulus: `if_arvalid` with `nextpc=0x80000000`; `mem_arready` in the first cycle; beats `0x00000297_00000413` then `0x00100073_0000006f` with `rlast`.
  - Response: `mem_araddr=0x80000000`; `cache_rdata=0x00000413` and `cache_rdata_valid` 1 cycle after the rlast beat; set 0 becomes valid.
- **Hit:** request `0x80000004`, then `0x8000000c` → `0x00000297`, then `0x00100073`, each at T+2 with no `mem_arvalid`.
- **Conflict eviction:**
  - Request `0x80000400` (same index 0 for SETS=64) → miss, refill from `0x80000400`.
  - Then `0x80000000` → miss again.
- **fence_i:**
  - Assert `fence_i` during a REFILL; the current response still completes.
  - The next request to the same line → miss and `mem_arvalid`.
  - `fence_i` together with `if_arvalid` in IDLE → that request misses.
- **Backpressure:** hold `mem_arready=0` for 5 cycles → `mem_arvalid` and `mem_araddr` stay stable; insert idle `mem_rvalid` gaps → data still correct.
- **Reset mid-refill:**
  - Assert `rst` after beat 0 → outputs return to reset values.
  - After reset, a request to the same address misses.

Source files
------------

// File: rtl/ysyx_22051086_icache_pkg.sv
// Shared types, constants and address-split helpers for the direct-mapped instruction cache.
package ysyx_22051086_icache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_AR,
        REFILL,
        RESP
    } state_t;

    localparam int LINE_BYTES = 16;
    localparam int BEATS      = 2;
    localparam int PADDR_W    = 32;
    localparam int OFFSET_W   = $clog2(LINE_BYTES);
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int BEAT_W     = LINE_W / BEATS;

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets);
        return PADDR_W - OFFSET_W - index_w(sets);
    endfunction

    // Word w of a line lives in bits [32w+31:32w].
    function automatic logic [31:0] word_of(input logic [LINE_W-1:0] line, input logic [1:0] sel);
        return line[32*sel +: 32];
    endfunction

endpackage

// File: rtl/ysyx_22051086_icache_data.sv
// Line storage: full-line write port, word-selected combinational read port; SRAM-macro replaceable.
module ysyx_22051086_icache_data
    import ysyx_22051086_icache_pkg::*;
#(
    parameter int  SETS  = 64,
    localparam int IDX_W = index_w(SETS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    input  logic [1:0]        rsel,
    output logic [31:0]       rdata
);

    logic [LINE_W-1:0] mem [SETS];

    // NOTE: the array has no reset; the valid bits in the top qualify every entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = word_of(mem[raddr], rsel);

endmodule

// File: rtl/ysyx_22051086_icache.sv
// Blocking direct-mapped I-cache: one fetch at a time, 2-beat line refill, whole-cache fence.i invalidation.
module ysyx_22051086_icache
    import ysyx_22051086_icache_pkg::*;
#(
    parameter int SETS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_arvalid,
    input  logic [63:0] nextpc,
    output logic [31:0] cache_rdata,
    output logic        cache_rdata_valid,
    input  logic        fence_i,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    output logic [31:0] mem_araddr,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rlast
);

    localparam int IDX_W = index_w(SETS);
    localparam int TAG_W = tag_w(SETS);

    state_t              state;
    logic [PADDR_W-1:0]  req_addr;
    logic [SETS-1:0]     valid;
    logic [TAG_W-1:0]    tags [SETS];
    logic [LINE_W-1:0]   line_buf;
    logic [LINE_W-1:0]   line_next;
    logic                beat_cnt;
    logic                fence_pend;

    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [1:0]          req_word;
    logic                hit;
    logic                refill_done;
    logic [31:0]         hit_word;
    logic                unused_bits;

    assign req_idx     = req_addr[OFFSET_W +: IDX_W];
    assign req_tag     = req_addr[PADDR_W-1 -: TAG_W];
    assign req_word    = req_addr[3:2];
    assign hit         = valid[req_idx] && (tags[req_idx] == req_tag);
    assign refill_done = (state == REFILL) && mem_rvalid && mem_rlast && !rst;
    assign unused_bits = ^{nextpc[63:32], req_addr[1:0]};

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        line_next = line_buf;
        if (beat_cnt) begin
            line_next[LINE_W-1 -: BEAT_W] = mem_rdata;
        end else begin
            line_next[BEAT_W-1:0] = mem_rdata;
        end
    end

    ysyx_22051086_icache_data #(
        .SETS (SETS)
    ) u_data (
        .clk   (clk),
        .we    (refill_done),
        .waddr (req_idx),
        .wdata (line_next),
        .raddr (req_idx),
        .rsel  (req_word),
        .rdata (hit_word)
    );

    always_ff @(posedge clk) begin
        if (refill_done) begin
            tags[req_idx] <= req_tag;
        end
    end

    // NOTE: non-blocking assignments so every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            req_addr          <= '0;
            valid             <= '0;
            fence_pend        <= 1'b0;
            line_buf          <= '0;
            beat_cnt          <= 1'b0;
            cache_rdata       <= '0;
            cache_rdata_valid <= 1'b0;
            mem_arvalid       <= 1'b0;
            mem_araddr        <= '0;
        end else begin
            cache_rdata_valid <= 1'b0;

            // A fence seen while busy is deferred to the first IDLE cycle.
            if (state == IDLE && (fence_i || fence_pend)) begin
                valid      <= '0;
                fence_pend <= 1'b0;
            end else if (state != IDLE && fence_i) begin
                fence_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (if_arvalid) begin
                        req_addr <= nextpc[PADDR_W-1:0];
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        cache_rdata       <= hit_word;
                        cache_rdata_valid <= 1'b1;
                        state             <= RESP;
                    end else begin
                        mem_arvalid <= 1'b1;
                        mem_araddr  <= {req_addr[PADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        state       <= MISS_AR;
                    end
                end
                MISS_AR: begin
                    if (mem_arready) begin
                        mem_arvalid <= 1'b0;
                        beat_cnt    <= 1'b0;
                        state       <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rvalid) begin
                        line_buf <= line_next;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (mem_rlast) begin
                            valid[req_idx]    <= 1'b1;
                            cache_rdata       <= word_of(line_next, req_word);
                            cache_rdata_valid <= 1'b1;
                            state             <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22051086_icache.sv
// Directed plus randomized fetch sequences checked against a line-address model of the cache.
module tb_ysyx_22051086_icache;

    localparam int SETS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_arvalid;
    logic [63:0] nextpc;
    logic [31:0] cache_rdata;
    logic        cache_rdata_valid;
    logic        fence_i;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_rlast;

    int checks = 0;
    int errors = 0;

    // Reference model: which line address each set currently holds.
    bit          ref_vld  [SETS];
    logic [31:0] ref_line [SETS];

    ysyx_22051086_icache #(
        .SETS (SETS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .if_arvalid        (if_arvalid),
        .nextpc            (nextpc),
        .cache_rdata       (cache_rdata),
        .cache_rdata_valid (cache_rdata_valid),
        .fence_i           (fence_i),
        .mem_arvalid       (mem_arvalid),
        .mem_arready       (mem_arready),
        .mem_araddr        (mem_araddr),
        .mem_rvalid        (mem_rvalid),
        .mem_rdata         (mem_rdata),
        .mem_rlast         (mem_rlast)
    );

    always #5 clk = ~clk;

    // Backing memory, word addressed; the first line holds the known program.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        case (wa)
            32'h8000_0000: return 32'h0000_0413;
            32'h8000_0004: return 32'h0000_0297;
            32'h8000_0008: return 32'h0000_006f;
            32'h8000_000c: return 32'h0010_0073;
            default:       return {wa[31:2], 2'b11} ^ 32'h1357_9bdf ^ {wa[15:0], 16'h0};
        endcase
    endfunction

    function automatic logic [63:0] beat_of(input logic [31:0] line, input int b);
        logic [31:0] lo;
        lo = line + 32'(8 * b);
        return {mem_word(lo + 32'd4), mem_word(lo)};
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 4) % SETS);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < SETS; i++) ref_vld[i] = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete fetch; the memory side answers with the given handshake delays.
    task automatic fetch(input logic [63:0] pc, input int ar_delay, input int gap,
                         input bit fence_mid, input bit fence_req);
        logic [31:0] a;
        logic [31:0] line;
        logic [31:0] exp_word;
        int          idx;
        bit          exp_hit;
        a        = pc[31:0];
        line     = {a[31:4], 4'b0};
        exp_word = mem_word(a);
        idx      = idx_of(a);
        if (fence_req) clear_model();
        exp_hit = ref_vld[idx] && (ref_line[idx] == line);

        @(negedge clk);
        if_arvalid = 1'b1;
        nextpc     = pc;
        fence_i    = fence_req;
        @(negedge clk);
        if_arvalid = 1'b0;
        fence_i    = 1'b0;
        nextpc     = {$urandom, $urandom};
        check("lookup_valid", cache_rdata_valid, 0);
        check("lookup_arvalid", mem_arvalid, 0);

        if (exp_hit) begin
            @(negedge clk);
            check("hit_valid", cache_rdata_valid, 1);
            check("hit_data", cache_rdata, exp_word);
            check("hit_arvalid", mem_arvalid, 0);
        end else begin
            @(negedge clk);
            check("miss_arvalid", mem_arvalid, 1);
            check("miss_araddr", mem_araddr, line);
            for (int i = 0; i < ar_delay; i++) begin
                mem_rvalid = 1'b1;
                mem_rdata  = {$urandom, $urandom};
                mem_rlast  = 1'($urandom);
                @(negedge clk);
                check("ar_hold_valid", mem_arvalid, 1);
                check("ar_hold_addr", mem_araddr, line);
            end
            mem_rvalid  = 1'b0;
            mem_rlast   = 1'b0;
            mem_arready = 1'b1;
            @(negedge clk);
            mem_arready = 1'b0;
            check("ar_drop", mem_arvalid, 0);
            for (int b = 0; b < 2; b++) begin
                for (int g = 0; g < gap; g++) begin
                    mem_rdata = {$urandom, $urandom};
                    @(negedge clk);
                end
                mem_rvalid = 1'b1;
                mem_rdata  = beat_of(line, b);
                mem_rlast  = (b == 1);
                fence_i    = fence_mid && (b == 0);
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rlast  = 1'b0;
                fence_i    = 1'b0;
                if (b == 0) check("beat0_no_resp", cache_rdata_valid, 0);
            end
            check("miss_valid", cache_rdata_valid, 1);
            check("miss_data", cache_rdata, exp_word);
            ref_vld[idx]  = 1'b1;
            ref_line[idx] = line;
            if (fence_mid) clear_model();
        end

        @(negedge clk);
        check("pulse_end", cache_rdata_valid, 0);
        check("rdata_hold", cache_rdata, exp_word);
    endtask

    initial begin
        logic [31:0] pa;
        rst         = 1'b1;
        if_arvalid  = 1'b0;
        nextpc      = '0;
        fence_i     = 1'b0;
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        mem_rlast   = 1'b0;
        clear_model();

        repeat (3) @(negedge clk);
        check("rst_rdata_valid", cache_rdata_valid, 0);
        check("rst_rdata", cache_rdata, 0);
        check("rst_arvalid", mem_arvalid, 0);
        check("rst_araddr", mem_araddr, 0);
        rst = 1'b0;

        // Cold miss, then hits in the same line.
        fetch(64'h0000_0000_8000_0000, 0, 0, 1'b0, 1'b0);
        fetch(64'h0000_0000_8000_0004, 0, 0, 1'b0, 1'b0);
        fetch(64'h0000_0000_8000_000c, 0, 0, 1'b0, 1'b0);
        fetch(64'hdead_beef_8000_0008, 0, 0, 1'b0, 1'b0);

        // Conflict on set 0.
        fetch(64'h0000_0000_8000_0400, 0, 0, 1'b0, 1'b0);
        fetch(64'h0000_0000_8000_0000, 0, 0, 1'b0, 1'b0);

        // fence.i during a refill, then fence.i coincident with a request.
        fetch(64'h0000_0000_8000_0010, 0, 0, 1'b1, 1'b0);
        fetch(64'h0000_0000_8000_0010, 0, 0, 1'b0, 1'b0);
        fetch(64'h0000_0000_8000_0014, 0, 0, 1'b0, 1'b1);

        // Address backpressure with stray rvalid, plus beat gaps.
        fetch(64'h0000_0000_8000_0020, 5, 2, 1'b0, 1'b0);

        // Reset after the first refill beat.
        pa = 32'h8000_0030;
        @(negedge clk);
        if_arvalid = 1'b1;
        nextpc     = {32'h0, pa};
        @(negedge clk);
        if_arvalid = 1'b0;
        @(negedge clk);
        check("rstmid_arvalid", mem_arvalid, 1);
        mem_arready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b0;
        mem_rvalid  = 1'b1;
        mem_rdata   = beat_of(pa, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        check("rstmid_rdata_valid", cache_rdata_valid, 0);
        check("rstmid_rdata", cache_rdata, 0);
        check("rstmid_arvalid_low", mem_arvalid, 0);
        check("rstmid_araddr", mem_araddr, 0);
        rst = 1'b0;
        clear_model();
        fetch({32'h0, pa}, 0, 0, 1'b0, 1'b0);
        fetch({32'h0, pa + 32'd8}, 0, 0, 1'b0, 1'b0);

        // Random traffic over a few conflicting tags and sets.
        for (int n = 0; n < 40; n++) begin
            pa = 32'h8000_0000 + (32'($urandom_range(0, 3)) << 10)
               + (32'($urandom_range(0, 7)) << 4) + (32'($urandom_range(0, 3)) << 2)
               + 32'($urandom_range(0, 3));
            fetch({$urandom, pa}, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
